ofmap_collector: RTL and testbench

Downstream stage of the PE array accelerator top. It captures the PE_X_SIZE-wide top-row psum vector (`ofmap`) whenever the controller flags it valid. It accumulates NUM_PASSES such vectors per output row in widened signed accumulators, then serializes the row one word per handshake, column 0 first, through a valid/ready port towards the output buffer.

---
 rtl/ofmap_collector_if.sv | 25 ++
 rtl/ofmap_collector.sv | 115 +++++++++++
 tb/tb_ofmap_collector.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ofmap_collector_if.sv
// Handshake bundle between the PE array top row, the ofmap collector and the output buffer.
// master is the collector side; slave is the side that feeds vectors and consumes words.
interface ofmap_collector_if #(
    parameter int BITWIDTH  = 16,
    parameter int PE_X_SIZE = 3
);
    logic [BITWIDTH*PE_X_SIZE-1:0] ofmap;
    logic                          ofmap_valid;
    logic                          ofmap_ready;
    logic [BITWIDTH-1:0]           out_data;
    logic                          out_valid;
    logic                          out_ready;
    logic                          out_last;
    logic                          overrun;

    modport master (
        input  ofmap, ofmap_valid, out_ready,
        output ofmap_ready, out_data, out_valid, out_last, overrun
    );

    modport slave (
        output ofmap, ofmap_valid, out_ready,
        input  ofmap_ready, out_data, out_valid, out_last, overrun
    );
endinterface

// File: rtl/ofmap_collector.sv
// Accumulates NUM_PASSES psum vectors per output row, then drains the row one saturated word per handshake.
// Optional feature macro: OFMAP_RELU_EN clamps negative output words to zero.
module ofmap_collector #(
    parameter int BITWIDTH     = 16,
    parameter int PE_X_SIZE    = 3,
    parameter int ACC_BITWIDTH = 24,
    parameter int NUM_PASSES   = 4
) (
    input  logic               clk,
    input  logic               rstb,
    ofmap_collector_if.master  bus
);
    localparam int PW = $clog2(NUM_PASSES + 1);
    localparam int CW = (PE_X_SIZE > 1) ? $clog2(PE_X_SIZE) : 1;
    localparam logic [PW-1:0] LAST_PASS = PW'(NUM_PASSES - 1);
    localparam logic [CW-1:0] LAST_COL  = CW'(PE_X_SIZE - 1);
    localparam logic signed [ACC_BITWIDTH-1:0] SAT_MAX =
        ACC_BITWIDTH'((64'sd1 <<< (BITWIDTH - 1)) - 64'sd1);
    localparam logic signed [ACC_BITWIDTH-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic {ACCUM, DRAIN} state_t;

    state_t                          state;
    logic signed [ACC_BITWIDTH-1:0]  acc [PE_X_SIZE];
    logic signed [ACC_BITWIDTH-1:0]  ext [PE_X_SIZE];
    logic [PW-1:0]                   pass_cnt;
    logic [CW-1:0]                   col_idx;
    logic                            ready_q;
    logic                            valid_q;
    logic                            overrun_q;
    logic signed [ACC_BITWIDTH-1:0]  sel;
    logic [BITWIDTH-1:0]             post_word;

    always_comb begin
        for (int j = 0; j < PE_X_SIZE; j++) begin
            ext[j] = ACC_BITWIDTH'($signed(bus.ofmap[j*BITWIDTH +: BITWIDTH]));
        end
    end

    // Output word is a pure function of the registered accumulator and column pointer.
    always_comb begin
        sel = acc[col_idx];
        if (sel > SAT_MAX) begin
            post_word = {1'b0, {(BITWIDTH-1){1'b1}}};
        end else if (sel < SAT_MIN) begin
            post_word = {1'b1, {(BITWIDTH-1){1'b0}}};
        end else begin
            post_word = sel[BITWIDTH-1:0];
        end
`ifdef OFMAP_RELU_EN
        if (post_word[BITWIDTH-1]) begin
            post_word = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rstb) begin
            state     <= ACCUM;
            pass_cnt  <= '0;
            col_idx   <= '0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            for (int j = 0; j < PE_X_SIZE; j++) begin
                acc[j] <= '0;
            end
        end else begin
            case (state)
                ACCUM: begin
                    if (bus.ofmap_valid) begin
                        for (int j = 0; j < PE_X_SIZE; j++) begin
                            acc[j] <= acc[j] + ext[j];
                        end
                        if (pass_cnt == LAST_PASS) begin
                            pass_cnt <= '0;
                            col_idx  <= '0;
                            state    <= DRAIN;
                            ready_q  <= 1'b0;
                            valid_q  <= 1'b1;
                        end else begin
                            pass_cnt <= pass_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // Vectors offered while draining are lost; flag it for software.
                    if (bus.ofmap_valid) begin
                        overrun_q <= 1'b1;
                    end
                    if (bus.out_ready) begin
                        if (col_idx == LAST_COL) begin
                            for (int j = 0; j < PE_X_SIZE; j++) begin
                                acc[j] <= '0;
                            end
                            col_idx <= '0;
                            state   <= ACCUM;
                            ready_q <= 1'b1;
                            valid_q <= 1'b0;
                        end else begin
                            col_idx <= col_idx + 1'b1;
                        end
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign bus.ofmap_ready = ready_q;
    assign bus.out_valid   = valid_q;
    assign bus.out_last    = valid_q && (col_idx == LAST_COL);
    assign bus.out_data    = post_word;
    assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_ofmap_collector.sv
// Scoreboard bench for ofmap_collector: a reference model pushes expected row words when vectors are
// driven and each scenario pops and compares them as the collector drains.
module tb_ofmap_collector;
    localparam int BW = 16;
    localparam int PX = 3;
    localparam int NP = 2;
    localparam int AW = 24;

    logic clk = 1'b0;
    logic rstb;
    int   checks = 0;
    int   errors = 0;
    logic [16:0] exp_q [$];
    int   model_acc [PX];
    int   model_pass;

    ofmap_collector_if #(.BITWIDTH(BW), .PE_X_SIZE(PX)) bus ();

    ofmap_collector #(
        .BITWIDTH(BW), .PE_X_SIZE(PX), .ACC_BITWIDTH(AW), .NUM_PASSES(NP)
    ) dut (
        .clk(clk),
        .rstb(rstb),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] exp_post(input int v);
        int s;
        s = (v > 32767) ? 32767 : ((v < -32768) ? -32768 : v);
`ifdef OFMAP_RELU_EN
        if (s < 0) s = 0;
`endif
        return 16'(s);
    endfunction

    task automatic model_clear();
        for (int j = 0; j < PX; j++) model_acc[j] = 0;
        model_pass = 0;
    endtask

    // Reference model: completes a row every NP accepted vectors.
    task automatic model_accept(input int a, input int b, input int c);
        model_acc[0] += a;
        model_acc[1] += b;
        model_acc[2] += c;
        model_pass++;
        if (model_pass == NP) begin
            for (int j = 0; j < PX; j++) exp_q.push_back({(j == PX-1), exp_post(model_acc[j])});
            model_clear();
        end
    endtask

    task automatic send_vector(input int a, input int b, input int c);
        bus.ofmap = {16'(c), 16'(b), 16'(a)};
        bus.ofmap_valid = 1'b1;
        @(posedge clk); #1;
        bus.ofmap_valid = 1'b0;
        model_accept(a, b, c);
    endtask

    task automatic do_reset();
        rstb = 1'b1;
        bus.ofmap_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rstb = 1'b0;
        exp_q.delete();
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (bus.ofmap_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b want 1", bus.ofmap_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_last: got %b want 0", bus.out_last); end
        checks++; if (bus.out_data !== 16'h0) begin errors++; $display("[TB] FAIL reset_data: got %h want 0000", bus.out_data); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun: got %b want 0", bus.overrun); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic_row();
        int w;
        logic [16:0] e;
        bus.out_ready = 1'b1;
        send_vector(10, 20, 30);
        send_vector(1, 2, 3);
        for (int k = 0; k < PX; k++) begin
            w = 0;
            @(negedge clk);
            while (bus.out_valid !== 1'b1 && w < 20) begin @(negedge clk); w++; end
            e = exp_q.pop_front();
            checks++; if (w != 0) begin errors++; $display("[TB] FAIL basic_latency: word %0d waited %0d cycles want 0", k, w); end
            checks++; if (bus.out_data !== e[15:0]) begin errors++; $display("[TB] FAIL basic_data: word %0d got %h want %h", k, bus.out_data, e[15:0]); end
            checks++; if (bus.out_last !== e[16]) begin errors++; $display("[TB] FAIL basic_last: word %0d got %b want %b", k, bus.out_last, e[16]); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_valid_off: got %b want 0", bus.out_valid); end
        checks++; if (bus.ofmap_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_ready_back: got %b want 1", bus.ofmap_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        int w;
        logic [16:0] e;
        bus.out_ready = 1'b1;
        send_vector(28672, -28672, 5);
        send_vector(28672, -28672, -9);
        for (int k = 0; k < PX; k++) begin
            w = 0;
            @(negedge clk);
            while (bus.out_valid !== 1'b1 && w < 20) begin @(negedge clk); w++; end
            e = exp_q.pop_front();
            checks++; if (w >= 20) begin errors++; $display("[TB] FAIL sat_timeout: word %0d never valid", k); end
            checks++; if (bus.out_data !== e[15:0]) begin errors++; $display("[TB] FAIL sat_data: word %0d got %h want %h", k, bus.out_data, e[15:0]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int w;
        logic [16:0] e;
        bus.out_ready = 1'b0;
        send_vector(10, 20, 30);
        send_vector(1, 2, 3);
        e = exp_q[0];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid: cycle %0d got %b want 1", i, bus.out_valid); end
            checks++; if (bus.out_data !== e[15:0]) begin errors++; $display("[TB] FAIL bp_data: cycle %0d got %h want %h", i, bus.out_data, e[15:0]); end
            checks++; if (bus.out_last !== 1'b0) begin errors++; $display("[TB] FAIL bp_last: cycle %0d got %b want 0", i, bus.out_last); end
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < PX; k++) begin
            w = 0;
            @(negedge clk);
            while (bus.out_valid !== 1'b1 && w < 20) begin @(negedge clk); w++; end
            e = exp_q.pop_front();
            checks++; if (bus.out_data !== e[15:0]) begin errors++; $display("[TB] FAIL bp_drain_data: word %0d got %h want %h", k, bus.out_data, e[15:0]); end
            checks++; if (bus.out_last !== e[16]) begin errors++; $display("[TB] FAIL bp_drain_last: word %0d got %b want %b", k, bus.out_last, e[16]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_overrun();
        int w;
        logic [16:0] e;
        bus.out_ready = 1'b0;
        send_vector(10, 20, 30);
        send_vector(1, 2, 3);
        bus.ofmap = {16'd100, 16'd100, 16'd100};
        bus.ofmap_valid = 1'b1;
        @(posedge clk); #1;
        bus.ofmap_valid = 1'b0;
        @(negedge clk);
        e = exp_q[0];
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("[TB] FAIL overrun_set: got %b want 1", bus.overrun); end
        checks++; if (bus.out_data !== e[15:0]) begin errors++; $display("[TB] FAIL overrun_hold: got %h want %h", bus.out_data, e[15:0]); end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            if (r == 1) begin
                send_vector(1, 2, 3);
                send_vector(4, 5, 6);
            end
            for (int k = 0; k < PX; k++) begin
                w = 0;
                @(negedge clk);
                while (bus.out_valid !== 1'b1 && w < 20) begin @(negedge clk); w++; end
                e = exp_q.pop_front();
                checks++; if (bus.out_data !== e[15:0]) begin errors++; $display("[TB] FAIL overrun_data: row %0d word %0d got %h want %h", r, k, bus.out_data, e[15:0]); end
                @(posedge clk); #1;
            end
        end
        @(negedge clk);
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("[TB] FAIL overrun_sticky: got %b want 1", bus.overrun); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int w;
        logic [16:0] e;
        bus.out_ready = 1'b1;
        send_vector(10, 20, 30);
        send_vector(1, 2, 3);
        for (int k = 0; k < 2; k++) begin
            w = 0;
            @(negedge clk);
            while (bus.out_valid !== 1'b1 && w < 20) begin @(negedge clk); w++; end
            e = exp_q.pop_front();
            checks++; if (bus.out_data !== e[15:0]) begin errors++; $display("[TB] FAIL rmid_pre_data: word %0d got %h want %h", k, bus.out_data, e[15:0]); end
            @(posedge clk); #1;
        end
        rstb = 1'b1;
        @(posedge clk); #1;
        rstb = 1'b0;
        exp_q.delete();
        model_clear();
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("[TB] FAIL rmid_overrun: got %b want 0", bus.overrun); end
        checks++; if (bus.ofmap_ready !== 1'b1) begin errors++; $display("[TB] FAIL rmid_ready: got %b want 1", bus.ofmap_ready); end
        @(posedge clk); #1;
        send_vector(1, 1, 1);
        send_vector(2, 2, 2);
        for (int k = 0; k < PX; k++) begin
            w = 0;
            @(negedge clk);
            while (bus.out_valid !== 1'b1 && w < 20) begin @(negedge clk); w++; end
            e = exp_q.pop_front();
            checks++; if (bus.out_data !== e[15:0]) begin errors++; $display("[TB] FAIL rmid_post_data: word %0d got %h want %h", k, bus.out_data, e[15:0]); end
            checks++; if (bus.out_last !== e[16]) begin errors++; $display("[TB] FAIL rmid_post_last: word %0d got %b want %b", k, bus.out_last, e[16]); end
            @(posedge clk); #1;
        end
    endtask

    // ofmap_valid held high across two rows; accepts only happen while the collector is in ACCUM.
    task automatic test_back_to_back();
        int va [10] = '{5, 8, 100, 100, 100, -1, -4, 100, 100, 100};
        int vb [10] = '{6, 9, -50, -50, -50, -2, -5, -50, -50, -50};
        int vc [10] = '{7, 10, 7, 7, 7, -3, -6, 7, 7, 7};
        logic [10:0] rdy_mask = 11'b10001100011;
        logic [10:0] vld_mask = 11'b01110011100;
        logic [16:0] e;
        do_reset();
        bus.out_ready = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            if (c < 10) begin
                bus.ofmap = {16'(vc[c]), 16'(vb[c]), 16'(va[c])};
                bus.ofmap_valid = 1'b1;
            end else begin
                bus.ofmap_valid = 1'b0;
            end
            @(negedge clk);
            checks++; if (bus.ofmap_ready !== rdy_mask[c]) begin errors++; $display("[TB] FAIL b2b_ready: cycle %0d got %b want %b", c, bus.ofmap_ready, rdy_mask[c]); end
            checks++; if (bus.out_valid !== vld_mask[c]) begin errors++; $display("[TB] FAIL b2b_valid: cycle %0d got %b want %b", c, bus.out_valid, vld_mask[c]); end
            if (vld_mask[c] && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++; if (bus.out_data !== e[15:0]) begin errors++; $display("[TB] FAIL b2b_data: cycle %0d got %h want %h", c, bus.out_data, e[15:0]); end
                checks++; if (bus.out_last !== e[16]) begin errors++; $display("[TB] FAIL b2b_last: cycle %0d got %b want %b", c, bus.out_last, e[16]); end
            end
            if (rdy_mask[c] && c < 10) model_accept(va[c], vb[c], vc[c]);
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("[TB] FAIL b2b_overrun: got %b want 1", bus.overrun); end
        @(posedge clk); #1;
    endtask

    initial begin
        bus.ofmap = '0;
        bus.ofmap_valid = 1'b0;
        bus.out_ready = 1'b1;
        rstb = 1'b1;
        model_clear();
        test_reset();
        test_basic_row();
        test_saturation();
        test_backpressure();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
